// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: read-owner
// encoding, starvation defaults and bus widths.
package mem_arbiter_pkg;

    // Which port owns the read that is currently in flight.
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_RD_IF = 2'd1,
        OWN_RD_D  = 2'd2
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int DATA_W         = 32;
    localparam int BE_W           = DATA_W / 8;

    // Counter width able to hold 0..max inclusive.
    function automatic int starve_cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles in which the fetch port asked
// for the memory and was refused.
module arb_starve_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CW         = starve_cnt_w(STARVE_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic          gnt_i,
    output logic [CW-1:0] cnt_o
);

    localparam logic [CW-1:0] LIM = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count refused cycles, stick at the limit, drop to zero once served or idle.
    always_comb begin
        cnt_d = '0;
        if (req_i && !gnt_i) begin
            cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous RAM. The data
// port wins contention unless the fetch port has been starved for
// STARVE_MAX cycles; read data returns one cycle after the grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 14,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [BE_W-1:0]   d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int            CW  = starve_cnt_w(STARVE_MAX);
    localparam logic [CW-1:0] LIM = CW'(STARVE_MAX);

    logic [CW-1:0]     starve_cnt;
    logic              force_if;
    owner_e            owner_q;
    owner_e            owner_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign force_if = (starve_cnt == LIM);

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        d_gnt  = rst && d_req && !(if_req && force_if);
        if_gnt = rst && if_req && !(d_req && !force_if);
    end

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .req_i (if_req),
        .gnt_i (if_gnt),
        .cnt_o (starve_cnt)
    );

    // Steer the winning port onto the RAM; bus is all-zero when idle.
    always_comb begin
        mem_en   = if_gnt || d_gnt;
        mem_we   = d_gnt ? d_we : '0;
        mem_addr = '0;
        mem_din  = d_gnt ? d_wdata : '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
    end

    // Owner of next cycle's RAM output follows this cycle's grant; stores own nothing.
    always_comb begin
        owner_d = OWN_IDLE;
        if (if_gnt) begin
            owner_d = OWN_RD_IF;
        end else if (d_gnt && (d_we == '0)) begin
            owner_d = OWN_RD_D;
        end
    end

    // Owner FSM; asynchronous reset drops any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign if_rvalid = (owner_q == OWN_RD_IF);
    assign d_rvalid  = (owner_q == OWN_RD_D);

    // Each port's last read word is kept so it holds between its own rvalids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_dout;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_dout;
            end
        end
    end

    assign if_rdata = if_rvalid ? mem_dout : if_rdata_q;
    assign d_rdata  = d_rvalid ? mem_dout : d_rdata_q;

endmodule
